// File: rtl/risc_pkg.sv
// ---------------------------------------------------------------------------
// risc_pkg
// Shared encodings for the 8-bit training CPU. The control sequencer, the ALU
// and the instruction register all use these.
//   opcode_t : 3-bit instruction opcode field
//   state_t  : 3-bit sequencer phase, one instruction = 8 phases
//   is_aluop : true for opcodes that read an operand and load the accumulator
// ---------------------------------------------------------------------------
package risc_pkg;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } state_t;

  // Opcodes that fetch a memory operand and write the accumulator.
  function automatic logic is_aluop(input opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/risc_sequencer.sv
// ---------------------------------------------------------------------------
// risc_sequencer
// Eight-phase control sequencer for the 8-bit training CPU. Each instruction
// takes exactly 8 clocks (INST_ADDR .. STORE, then wrap). The strobes are a
// pure combinational decode of the phase, opcode, zero flag and halted flag;
// consumers sample them on the next rising edge.
//
// Optional build macro:
//   SEQ_STEP_EN : adds the step input. The FSM waits in INST_ADDR (all
//                 outputs 0) until step is sampled high, then runs one whole
//                 instruction. Holding step high runs continuously.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_      in   asynchronous active-low reset
//   opcode    in   [2:0] opcode from the instruction register
//   zero      in   accumulator-is-zero flag from the ALU
//   step      in   single-step request (SEQ_STEP_EN builds only)
//   mem_rd    out  memory read strobe
//   load_ir   out  instruction register enable
//   halt      out  processor halted
//   inc_pc    out  program counter increment
//   load_ac   out  accumulator enable
//   load_pc   out  program counter load
//   mem_wr    out  memory write strobe
//   dbg_state out  [2:0] current sequencer phase (state_t encoding)
//
// Handshake: there is none. Strobes are single-phase enables, valid for the
// whole cycle they are asserted and consumed on the following rising edge;
// nothing feeds back from a strobe into the FSM.
// ---------------------------------------------------------------------------
module risc_sequencer
  import risc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_,
  input  logic [2:0] opcode,
  input  logic       zero,
`ifdef SEQ_STEP_EN
  input  logic       step,
`endif
  output logic       mem_rd,
  output logic       load_ir,
  output logic       halt,
  output logic       inc_pc,
  output logic       load_ac,
  output logic       load_pc,
  output logic       mem_wr,
  output logic [2:0] dbg_state
);

  state_t  r_state;
  logic    r_halted_q;
  state_t  w_next_state;
  logic    w_next_halted;
  opcode_t w_op;
  logic    w_aluop;
  logic    w_start;

  assign w_op      = opcode_t'(opcode);
  assign w_aluop   = is_aluop(w_op);
  assign dbg_state = r_state;

`ifdef SEQ_STEP_EN
  assign w_start = step;
`else
  assign w_start = 1'b1;
`endif

  // State and sticky halt register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state    <= INST_ADDR;
      r_halted_q <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_halted_q <= w_next_halted;
    end
  end

  // Next-state logic. Once halted the FSM is frozen until reset.
  always_comb begin
    w_next_state  = r_state;
    w_next_halted = r_halted_q;
    if (!r_halted_q) begin
      case (r_state)
        INST_ADDR:  if (w_start) w_next_state = INST_FETCH;
        INST_FETCH: w_next_state = INST_LOAD;
        INST_LOAD:  w_next_state = IDLE;
        IDLE:       w_next_state = OP_ADDR;
        OP_ADDR: begin
          // HLT latches the halt flag and parks the FSM in OP_ADDR.
          if (w_op == HLT) w_next_halted = 1'b1;
          else             w_next_state  = OP_FETCH;
        end
        OP_FETCH:   w_next_state = ALU_OP;
        ALU_OP:     w_next_state = STORE;
        STORE:      w_next_state = INST_ADDR;
        default:    w_next_state = INST_ADDR;
      endcase
    end
  end

  // Output decode.
  always_comb begin
    mem_rd  = 1'b0;
    load_ir = 1'b0;
    halt    = 1'b0;
    inc_pc  = 1'b0;
    load_ac = 1'b0;
    load_pc = 1'b0;
    mem_wr  = 1'b0;
    if (r_halted_q) begin
      halt = 1'b1;
    end else begin
      case (r_state)
        INST_ADDR: ;
        INST_FETCH: mem_rd = 1'b1;
        INST_LOAD, IDLE: begin
          mem_rd  = 1'b1;
          load_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (w_op == HLT);
        end
        OP_FETCH: mem_rd = w_aluop;
        ALU_OP: begin
          mem_rd  = w_aluop;
          load_ac = w_aluop;
          inc_pc  = (w_op == SKZ) && zero;
          load_pc = (w_op == JMP);
        end
        STORE: begin
          mem_rd  = w_aluop;
          load_ac = w_aluop;
          inc_pc  = (w_op == JMP);
          load_pc = (w_op == JMP);
          mem_wr  = (w_op == STO);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_risc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_risc_sequencer
// Self-checking bench for risc_sequencer. A phase-counter model derives every
// strobe from the per-signal rules; a negedge compare process checks all
// outputs and the debug state each cycle. Directed instructions capture each
// strobe as an 8-bit per-phase mask and check it against hand-written masks.
// Step tests are compiled in only with SEQ_STEP_EN.
// ---------------------------------------------------------------------------
module tb_risc_sequencer;

  // ---------------- clock / reset ----------------
  logic       clk  = 1'b0;
  logic       rst_ = 1'b1;
  logic [2:0] opcode = 3'd6;
  logic       zero   = 1'b1;
`ifdef SEQ_STEP_EN
  logic       step   = 1'b0;
`endif
  logic       mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  risc_sequencer dut (
    .clk      (clk),
    .rst_     (rst_),
    .opcode   (opcode),
    .zero     (zero),
`ifdef SEQ_STEP_EN
    .step     (step),
`endif
    .mem_rd   (mem_rd),
    .load_ir  (load_ir),
    .halt     (halt),
    .inc_pc   (inc_pc),
    .load_ac  (load_ac),
    .load_pc  (load_pc),
    .mem_wr   (mem_wr),
    .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- behavioural model ----------------
  int   m_phase  = 0;
  logic m_halted = 1'b0;
  logic step_gate;

`ifdef SEQ_STEP_EN
  assign step_gate = step;
`else
  assign step_gate = 1'b1;
`endif

  always @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      m_phase  <= 0;
      m_halted <= 1'b0;
    end else if (m_halted) begin
      m_phase <= m_phase;
    end else if (m_phase == 4 && opcode == 3'd0) begin
      m_halted <= 1'b1;
    end else if (m_phase == 0 && !step_gate) begin
      m_phase <= 0;
    end else begin
      m_phase <= (m_phase + 1) % 8;
    end
  end

  // Vector order: {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr}
  function automatic logic [6:0] exp_vec(input int ph, input logic h,
                                         input logic [2:0] op, input logic z);
    logic alu;
    logic [6:0] v;
    alu = (op >= 3'd2) && (op <= 3'd5);
    if (h) return 7'b0010000;
    v[6] = (ph >= 1 && ph <= 3) || (alu && ph >= 5);
    v[5] = (ph == 2) || (ph == 3);
    v[4] = (ph == 4) && (op == 3'd0);
    v[3] = (ph == 4) || (ph == 6 && op == 3'd1 && z) || (ph == 7 && op == 3'd7);
    v[2] = alu && ph >= 6;
    v[1] = (op == 3'd7) && ph >= 6;
    v[0] = (op == 3'd6) && ph == 7;
    return v;
  endfunction

  // ---------------- compare process + capture ----------------
  logic       cap_en = 1'b0;
  logic [7:0] cap [7];

  always @(negedge clk) begin
    logic [6:0] e;
    logic [6:0] a;
    logic [2:0] ps;
    e  = exp_vec(m_phase, m_halted, opcode, zero);
    a  = {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr};
    ps = m_phase[2:0];
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL outputs t=%0t ph=%0d op=%0d z=%b: got %b want %b",
               $time, m_phase, opcode, zero, a, e);
    end
    total++;
    if (dbg_state !== ps) begin
      bad++;
      $display("FAIL state t=%0t: got %0d want %0d", $time, dbg_state, ps);
    end
    if (cap_en)
      for (int i = 0; i < 7; i++) cap[i][ps] = a[i];
  end

  // ---------------- scoreboard for literal masks ----------------
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Runs one instruction from INST_ADDR and checks each strobe's per-phase
  // mask. masks = {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr}.
  task automatic run_instr(input string name, input logic [2:0] op,
                           input logic z, input logic [55:0] masks);
    string nm [7];
    logic [7:0] w;
    nm = '{"mem_wr", "load_pc", "load_ac", "inc_pc", "halt", "load_ir", "mem_rd"};
    for (int i = 6; i >= 0; i--) exp_q.push_back(masks[i*8 +: 8]);
    opcode = op;
    zero   = z;
    for (int i = 0; i < 7; i++) cap[i] = 8'h00;
    cap_en = 1'b1;
`ifdef SEQ_STEP_EN
    step = 1'b1;
    cyc();
    step = 1'b0;
    repeat (7) cyc();
`else
    repeat (8) cyc();
`endif
    cap_en = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      w = exp_q.pop_front();
      chk({name, ".", nm[i]}, cap[i], w);
    end
  endtask

  // ---------------- stimulus ----------------
  int hcnt;

  initial begin
    // Reset with STO / zero=1 applied.
    #1 rst_ = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset.state", {5'd0, dbg_state}, 8'h00);
    chk("reset.outs", {1'b0, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr}, 8'h00);
`ifdef SEQ_STEP_EN
    step = 1'b1;
`endif
    rst_ = 1'b1;
    cyc();
`ifdef SEQ_STEP_EN
    step = 1'b0;
`endif
    chk("reset.first_edge", {5'd0, dbg_state}, 8'h01);
    repeat (7) cyc();
    chk("reset.wrap", {5'd0, dbg_state}, 8'h00);

    // Directed instructions.
    run_instr("lda",   3'd5, 1'b0, {8'hEE, 8'h0C, 8'h00, 8'h10, 8'hC0, 8'h00, 8'h00});
    run_instr("skz_z1",3'd1, 1'b1, {8'h0E, 8'h0C, 8'h00, 8'h50, 8'h00, 8'h00, 8'h00});
    run_instr("skz_z0",3'd1, 1'b0, {8'h0E, 8'h0C, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00});
    run_instr("jmp",   3'd7, 1'b0, {8'h0E, 8'h0C, 8'h00, 8'h90, 8'h00, 8'hC0, 8'h00});
    run_instr("sto",   3'd6, 1'b1, {8'h0E, 8'h0C, 8'h00, 8'h10, 8'h00, 8'h00, 8'h80});
    run_instr("add",   3'd2, 1'b1, {8'hEE, 8'h0C, 8'h00, 8'h10, 8'hC0, 8'h00, 8'h00});

    // HLT: reach OP_ADDR, then freeze.
    opcode = 3'd0;
`ifdef SEQ_STEP_EN
    step = 1'b1;
    cyc();
    step = 1'b0;
    repeat (3) cyc();
`else
    repeat (4) cyc();
`endif
    chk("hlt.op_addr", {1'b0, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr}, 8'h18);
    cyc();
    opcode = 3'd2;
    repeat (22) cyc();
    chk("hlt.frozen", {1'b0, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr}, 8'h10);
    chk("hlt.state", {5'd0, dbg_state}, 8'h04);
    rst_ = 1'b0;
    #1;
    chk("hlt.reset_clears", {1'b0, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr}, 8'h00);
    chk("hlt.reset_state", {5'd0, dbg_state}, 8'h00);
    cyc();
    rst_ = 1'b1;

    // Randomized run, model checked every cycle by the compare process.
    hcnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)
        opcode = ($urandom_range(0, 19) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      zero = 1'($urandom_range(0, 1));
`ifdef SEQ_STEP_EN
      step = ($urandom_range(0, 3) != 0);
`endif
      if (m_halted) hcnt++;
      if (hcnt > 6) begin
        rst_ = 1'b0;
        #1;
        rst_ = 1'b1;
        hcnt = 0;
        opcode = 3'($urandom_range(1, 7));
      end
      cyc();
    end

`ifdef SEQ_STEP_EN
    // Single-step behaviour.
    rst_ = 1'b0;
    #1;
    rst_ = 1'b1;
    step = 1'b0;
    opcode = 3'd5;
    repeat (10) cyc();
    chk("step.wait", {5'd0, dbg_state}, 8'h00);
    step = 1'b1;
    cyc();
    step = 1'b0;
    chk("step.start", {5'd0, dbg_state}, 8'h01);
    repeat (7) cyc();
    chk("step.pass_done", {5'd0, dbg_state}, 8'h00);
    repeat (5) cyc();
    chk("step.waits_again", {5'd0, dbg_state}, 8'h00);
    step = 1'b1;
    cyc();
    step = 1'b0;
    repeat (4) cyc();
    chk("step.mid_pass", {5'd0, dbg_state}, 8'h05);
    rst_ = 1'b0;
    #1;
    chk("step.abort", {5'd0, dbg_state}, 8'h00);
    rst_ = 1'b1;
    repeat (5) cyc();
    chk("step.abort_wait", {5'd0, dbg_state}, 8'h00);
`endif

    repeat (2) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
